// File: rtl/bc_pkg.sv
// Shared bus-connect definitions: destination-select encodings used by both
// the bus-connect source mux and the destination distributor.
package bc_pkg;

    localparam int BC_SCLT_W = 2;

    typedef enum logic [BC_SCLT_W-1:0] {
        BC_DST_DG   = 2'b00,
        BC_DST_PS   = 2'b01,
        BC_DST_DM   = 2'b10,
        BC_DST_NONE = 2'b11
    } bc_dst_e;

    // True for destinations that take a register index alongside the data.
    function automatic logic bc_dst_is_reg(input logic [BC_SCLT_W-1:0] sclt);
        return (sclt == BC_DST_DG) || (sclt == BC_DST_PS);
    endfunction

endpackage

// File: rtl/bc_dm_fifo.sv
// Data-memory write buffer: DEPTH-entry FIFO with no fall-through.
// dout reads as zero while empty so nothing stale is ever presented.
module bc_dm_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo DEPTH; count is unchanged on simultaneous push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bc_dest.sv
// Bus-connect destination distributor: routes the bus-connect data word to
// DAG or PS register writes, or into the data-memory write buffer.
module bc_dest
    import bc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        bc_dt,
    input  logic                 ps_bc_dst_vld,
    input  logic [BC_SCLT_W-1:0] ps_bc_dst_sclt,
    input  logic [AW-1:0]        ps_bc_dst_addr,
    input  logic                 dm_bc_rdy,
    output logic                 bc_dg_wen,
    output logic [AW-1:0]        bc_dg_addr,
    output logic [DW-1:0]        bc_dg_dt,
    output logic                 bc_ps_wen,
    output logic [AW-1:0]        bc_ps_addr,
    output logic [DW-1:0]        bc_ps_dt,
    output logic                 bc_dm_wen,
    output logic [DW-1:0]        bc_dm_dt,
    output logic                 bc_ps_stall,
    output logic                 bc_dst_err
);

    logic accept;
    logic dm_push;
    logic dm_pop;
    logic dm_empty;
    logic dm_full;

    // Stall comes straight from the buffer's registered count, so a stalled
    // request is dropped for every destination, not just data memory.
    assign accept      = ps_bc_dst_vld & ~dm_full;
    assign dm_push     = accept & (ps_bc_dst_sclt == BC_DST_DM);
    assign dm_pop      = ~dm_empty & dm_bc_rdy;
    assign bc_dm_wen   = ~dm_empty;
    assign bc_ps_stall = dm_full;

    bc_dm_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_dm_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dm_push),
        .pop   (dm_pop),
        .din   (bc_dt),
        .dout  (bc_dm_dt),
        .empty (dm_empty),
        .full  (dm_full)
    );

    // Register writes: one-cycle wen pulses, address/data held between writes,
    // and a sticky error for the illegal destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_dg_wen  <= 1'b0;
            bc_dg_addr <= '0;
            bc_dg_dt   <= '0;
            bc_ps_wen  <= 1'b0;
            bc_ps_addr <= '0;
            bc_ps_dt   <= '0;
            bc_dst_err <= 1'b0;
        end else begin
            bc_dg_wen <= 1'b0;
            bc_ps_wen <= 1'b0;
            if (accept) begin
                case (bc_dst_e'(ps_bc_dst_sclt))
                    BC_DST_DG: begin
                        bc_dg_wen  <= 1'b1;
                        bc_dg_addr <= ps_bc_dst_addr;
                        bc_dg_dt   <= bc_dt;
                    end
                    BC_DST_PS: begin
                        bc_ps_wen  <= 1'b1;
                        bc_ps_addr <= ps_bc_dst_addr;
                        bc_ps_dt   <= bc_dt;
                    end
                    BC_DST_NONE: begin
                        bc_dst_err <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bc_dest.sv
// Self-checking bench for bc_dest: a behavioural model holds expected register
// writes and buffer contents in queues and compares them as the DUT emits them.
module tb_bc_dest;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] bc_dt = '0;
    logic          ps_bc_dst_vld = 1'b0;
    logic [1:0]    ps_bc_dst_sclt = 2'b00;
    logic [AW-1:0] ps_bc_dst_addr = '0;
    logic          dm_bc_rdy = 1'b0;
    logic          bc_dg_wen;
    logic [AW-1:0] bc_dg_addr;
    logic [DW-1:0] bc_dg_dt;
    logic          bc_ps_wen;
    logic [AW-1:0] bc_ps_addr;
    logic [DW-1:0] bc_ps_dt;
    logic          bc_dm_wen;
    logic [DW-1:0] bc_dm_dt;
    logic          bc_ps_stall;
    logic          bc_dst_err;

    int testsRun  = 0;
    int testsFail = 0;

    // Expected model state
    logic [AW+DW-1:0] dgQ[$];
    logic [AW+DW-1:0] psQ[$];
    logic [DW-1:0]    dmQ[$];
    logic [AW-1:0]    lastDgAddr = '0;
    logic [DW-1:0]    lastDgDt   = '0;
    logic [AW-1:0]    lastPsAddr = '0;
    logic [DW-1:0]    lastPsDt   = '0;
    logic             expErr     = 1'b0;

    bc_dest #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bc_dt          (bc_dt),
        .ps_bc_dst_vld  (ps_bc_dst_vld),
        .ps_bc_dst_sclt (ps_bc_dst_sclt),
        .ps_bc_dst_addr (ps_bc_dst_addr),
        .dm_bc_rdy      (dm_bc_rdy),
        .bc_dg_wen      (bc_dg_wen),
        .bc_dg_addr     (bc_dg_addr),
        .bc_dg_dt       (bc_dg_dt),
        .bc_ps_wen      (bc_ps_wen),
        .bc_ps_addr     (bc_ps_addr),
        .bc_ps_dt       (bc_ps_dt),
        .bc_dm_wen      (bc_dm_wen),
        .bc_dm_dt       (bc_dm_dt),
        .bc_ps_stall    (bc_ps_stall),
        .bc_dst_err     (bc_dst_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Compare every output against the model after an edge has settled.
    task automatic checkState();
        logic [AW+DW-1:0] e;
        checkOutput("dg_wen", 32'(bc_dg_wen), 32'(dgQ.size() != 0));
        if (dgQ.size() != 0) begin
            e = dgQ.pop_front();
            lastDgAddr = e[AW+DW-1:DW];
            lastDgDt   = e[DW-1:0];
        end
        checkOutput("dg_addr", 32'(bc_dg_addr), 32'(lastDgAddr));
        checkOutput("dg_dt", 32'(bc_dg_dt), 32'(lastDgDt));
        checkOutput("ps_wen", 32'(bc_ps_wen), 32'(psQ.size() != 0));
        if (psQ.size() != 0) begin
            e = psQ.pop_front();
            lastPsAddr = e[AW+DW-1:DW];
            lastPsDt   = e[DW-1:0];
        end
        checkOutput("ps_addr", 32'(bc_ps_addr), 32'(lastPsAddr));
        checkOutput("ps_dt", 32'(bc_ps_dt), 32'(lastPsDt));
        checkOutput("dm_wen", 32'(bc_dm_wen), 32'(dmQ.size() != 0));
        if (dmQ.size() != 0) begin
            checkOutput("dm_head", 32'(bc_dm_dt), 32'(dmQ[0]));
        end
        checkOutput("stall", 32'(bc_ps_stall), 32'(dmQ.size() == DEPTH));
        checkOutput("err", 32'(bc_dst_err), 32'(expErr));
    endtask

    // Drive one cycle of inputs, update the model across the edge, then check.
    task automatic applyStimulus(input logic vld, input logic [1:0] sclt, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] dt, input logic rdy);
        logic accept;
        ps_bc_dst_vld  = vld;
        ps_bc_dst_sclt = sclt;
        ps_bc_dst_addr = addr;
        bc_dt          = dt;
        dm_bc_rdy      = rdy;
        accept = vld && (dmQ.size() < DEPTH);
        if (rdy && dmQ.size() != 0) begin
            checkOutput("dm_emit", 32'(bc_dm_dt), 32'(dmQ.pop_front()));
        end
        @(posedge clk);
        if (accept) begin
            case (sclt)
                2'b00:   dgQ.push_back({addr, dt});
                2'b01:   psQ.push_back({addr, dt});
                2'b10:   dmQ.push_back(dt);
                default: expErr = 1'b1;
            endcase
        end
        #1;
        checkState();
    endtask

    // Assert reset away from the clock edge, check outputs clear at once, release.
    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_dg_wen", 32'(bc_dg_wen), 32'd0);
        checkOutput("rst_ps_wen", 32'(bc_ps_wen), 32'd0);
        checkOutput("rst_dm_wen", 32'(bc_dm_wen), 32'd0);
        checkOutput("rst_stall", 32'(bc_ps_stall), 32'd0);
        checkOutput("rst_err", 32'(bc_dst_err), 32'd0);
        checkOutput("rst_addr", 32'({bc_dg_addr, bc_ps_addr}), 32'd0);
        checkOutput("rst_dg_dt", 32'(bc_dg_dt), 32'd0);
        checkOutput("rst_ps_dt", 32'(bc_ps_dt), 32'd0);
        checkOutput("rst_dm_dt", 32'(bc_dm_dt), 32'd0);
        dgQ.delete();
        psQ.delete();
        dmQ.delete();
        lastDgAddr = '0;
        lastDgDt   = '0;
        lastPsAddr = '0;
        lastPsDt   = '0;
        expErr     = 1'b0;
        ps_bc_dst_vld = 1'b0;
        dm_bc_rdy     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        pulseReset();

        // Idle cycles with rdy high on an empty buffer must not pop anything.
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);

        // DAG write, then hold; PS write, then hold.
        applyStimulus(1'b1, 2'b00, 4'd3, 16'hA5A5, 1'b0);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'b01, 4'd5, 16'h1234, 1'b0);
        applyStimulus(1'b0, 2'b01, 4'd9, 16'hFFFF, 1'b0);
        applyStimulus(1'b1, 2'b01, 4'd15, 16'h8001, 1'b0);

        // Fill the buffer; the third write and a DAG write while stalled are dropped.
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0001, 1'b0);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0002, 1'b0);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0003, 1'b0);
        applyStimulus(1'b1, 2'b00, 4'd7, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 2'b11, 4'd0, 16'h0000, 1'b0);

        // Drain from full.
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);

        // Occupancy one, then simultaneous push and pop across pointer wraps.
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0010, 1'b0);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h00FF, 1'b1);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0100, 1'b1);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0101, 1'b1);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h0102, 1'b1);
        applyStimulus(1'b0, 2'b10, 4'd0, 16'h0000, 1'b1);

        // Random legal traffic.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                          AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);

        // Illegal destination sets a sticky error and writes nothing.
        applyStimulus(1'b1, 2'b11, 4'd2, 16'hDEAD, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b0);
        end

        // Reset with the buffer full: everything clears immediately, nothing stale after.
        applyStimulus(1'b1, 2'b10, 4'd0, 16'hCAFE, 1'b0);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'hF00D, 1'b0);
        checkOutput("full_before_rst", 32'(bc_ps_stall), 32'd1);
        pulseReset();
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 2'b10, 4'd0, 16'h4242, 1'b0);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/bc_dest.md
BC_DEST -- requirements
Module: bc_dest

Interface
REQ-001 SHALL have parameter DW, default 16: width of the bus-connect data word.
REQ-002 SHALL have parameter AW, default 4: width of the destination register index.
REQ-003 SHALL have parameter DEPTH, default 2: number of entries in the data-memory write buffer.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port bc_dt, input, DW: bus-connect data word to be distributed.
REQ-007 SHALL have port ps_bc_dst_vld, input, 1: the program sequencer presents a write request this cycle.
REQ-008 SHALL have port ps_bc_dst_sclt, input, 2: destination select. 00 = DAG register, 01 = PS register, 10 = data-memory write, 11 = illegal.
REQ-009 SHALL have port ps_bc_dst_addr, input, AW: destination register index, used for 00 and 01 only.
REQ-010 SHALL have port dm_bc_rdy, input, 1: data memory accepts the presented write this cycle.
REQ-011 SHALL have ports bc_dg_wen (1), bc_dg_addr (AW) and bc_dg_dt (DW), all outputs: DAG register write.
REQ-012 SHALL have ports bc_ps_wen (1), bc_ps_addr (AW) and bc_ps_dt (DW), all outputs: PS register write.
REQ-013 SHALL have ports bc_dm_wen (1) and bc_dm_dt (DW), both outputs: data-memory write request and data.
REQ-014 SHALL have port bc_ps_stall, output, 1: write buffer full; the sequencer must hold its request.
REQ-015 SHALL have port bc_dst_err, output, 1: sticky flag set by an illegal destination request.

Function
REQ-016 SHALL accept a request when ps_bc_dst_vld=1 and bc_ps_stall=0; requests made while stalled SHALL be ignored for every destination.
REQ-017 SHALL, for an accepted 00 or 01 request, on the next edge drive the matching wen=1 for exactly one cycle, with addr and dt equal to the sampled inputs.
REQ-018 SHALL hold dg and ps addr/dt at their last written values while wen=0.
REQ-019 SHALL push an accepted 10 request's bc_dt into a FIFO of DEPTH entries; the entry is visible no earlier than the next cycle (no fall-through).
REQ-020 SHALL drive bc_dm_wen=1 whenever the FIFO is non-empty, with bc_dm_dt equal to the head entry.
REQ-021 SHALL pop the head on an edge where bc_dm_wen=1 and dm_bc_rdy=1.
REQ-022 SHALL keep the occupancy count unchanged on a simultaneous push and pop; push is only possible when count<DEPTH.
REQ-023 SHALL drive bc_ps_stall = (count==DEPTH), decoded from registered state only, with no combinational path from any input.
REQ-024 SHALL ignore dm_bc_rdy while the FIFO is empty; no pop occurs and the count stays 0.
REQ-025 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-026 SHALL, for an accepted 11 request, generate no write and set bc_dst_err=1 on the next edge; the flag is cleared only by reset.
REQ-027 SHALL leave the data path width-exact: no sign extension, no truncation.

Reset
REQ-028 SHALL, while rst_n=0, immediately force all wen outputs, bc_ps_stall and bc_dst_err to 0, and all addr and dt outputs to 0.
REQ-029 SHALL, on reset mid-operation, discard all FIFO contents and reset pointers and count to 0.
REQ-030 SHALL accept requests from the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL take the destination-select encodings (DG, PS, DM, NONE) as named constants from shared package bc_pkg, which the bus-connect source mux also uses.
REQ-032 SHALL implement the write buffer as a sub-module bc_dm_fifo (parameters DW and DEPTH; ports push, pop, din, dout, empty, full).

Verification
REQ-033 SHALL cover: sclt=00, addr=3, bc_dt=16'hA5A5, vld=1 -> next cycle bc_dg_wen=1, bc_dg_addr=3, bc_dg_dt=16'hA5A5; following cycle wen=0.
REQ-034 SHALL cover: three back-to-back sclt=10 writes (16'h0001, 16'h0002, 16'h0003) with dm_bc_rdy=0 -> stall=1 after the second; the third is ignored; bc_dm_dt=16'h0001.
REQ-035 SHALL cover: from the full state, dm_bc_rdy=1 for 2 cycles -> 16'h0001 then 16'h0002 emitted, stall falls after the first pop, then bc_dm_wen=0.
REQ-036 SHALL cover: count=1, simultaneous push of 16'h00FF and pop over 4 cycles with rdy=1 -> data emitted in order, count stays 1, pointers wrap correctly.
REQ-037 SHALL cover: sclt=11 with vld=1 -> no wen of any kind, bc_dst_err=1 and held until rst_n=0.
REQ-038 SHALL cover: rst_n pulsed low with the FIFO full -> bc_dm_wen=0 and bc_ps_stall=0 immediately; no stale data after release.
